// File: rtl/wallace_mac_accumulator.sv
// Dot-product accumulator behind the pipelined Wallace multiplier, with a 2-entry result FIFO.
// Optional MAC_ACC_SAT_EN: the group sum saturates at all-ones instead of wrapping.
module wallace_mac_accumulator #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned PROD_W  = 32,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_last,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy,
  output logic              overflow_err
);

  logic [LATENCY-1:0] dl_v;
  logic [LATENCY-1:0] dl_l;
  logic               tap_v;
  logic               tap_l;

  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt;

  logic [ACC_W-1:0]   mem_data [2];
  logic [CNT_W-1:0]   mem_cnt  [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         fill;
  logic               push;
  logic               pop;
  logic               full;
  logic               push_ok;

  // Tag delay line; 'last' is stored pre-qualified by 'valid'.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v <= '0;
      dl_l <= '0;
    end else begin
      dl_v[0] <= issue_valid;
      dl_l[0] <= issue_valid & issue_last;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_l[i] <= dl_l[i-1];
      end
    end
  end

  assign tap_v = dl_v[LATENCY-1];
  assign tap_l = dl_l[LATENCY-1];

`ifdef MAC_ACC_SAT_EN
  logic [ACC_W:0] sum_ext;
  // An all-ones accumulator carries out on any nonzero addend, so saturation sticks.
  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, ACC_W'(product)};
    sum     = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
  end
`else
  always_comb begin
    sum = acc + ACC_W'(product);
  end
`endif

  assign cnt = count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
    end else if (tap_v) begin
      if (tap_l) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= cnt;
      end
    end
  end

  assign push    = tap_v & tap_l;
  assign pop     = out_valid & out_ready;
  assign full    = (fill == 2'd2);
  assign push_ok = push & (~full | pop);

  // When full, wr_ptr == rd_ptr: a same-cycle pop frees the very slot being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data[0]  <= '0;
      mem_data[1]  <= '0;
      mem_cnt[0]   <= '0;
      mem_cnt[1]   <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fill         <= 2'd0;
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_data[wr_ptr] <= sum;
        mem_cnt[wr_ptr]  <= cnt;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push_ok, pop})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
      if (push & ~push_ok) begin
        overflow_err <= 1'b1;
      end
    end
  end

  assign out_valid = (fill != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_count = mem_cnt[rd_ptr];
  assign busy      = (|dl_v) | (count != '0);

endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// Directed self-checking bench for wallace_mac_accumulator (ACC_W=32 instance).
module tb_wallace_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_last = 1'b0;
  logic [31:0] product;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        busy;
  logic        overflow_err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] pend_prod = 32'hDEAD_BEEF;
  logic [31:0] pp [4];

  wallace_mac_accumulator #(
    .LATENCY(4),
    .PROD_W(32),
    .ACC_W(32),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_last(issue_last),
    .product(product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count),
    .busy(busy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the multiplier pipeline: product appears 4 cycles after issue.
  always @(posedge clk) begin
    pp[0] <= pend_prod;
    pp[1] <= pp[0];
    pp[2] <= pp[1];
    pp[3] <= pp[2];
  end
  assign product = pp[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic tick(input logic v, input logic l, input logic [31:0] p);
    issue_valid = v;
    issue_last  = l;
    pend_prod   = v ? p : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!out_valid && n < max_cycles) begin
      tick(1'b0, 1'b0, 32'd0);
      n++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wait_valid: out_valid=%b required 1 within %0d cycles", out_valid, max_cycles); end
  endtask

  task automatic do_reset();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    out_ready   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", out_data); end
    n_cmp++; if (out_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", out_count); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    tick(1'b1, 1'b1, 32'h0000_0006);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int c = 1; c < 4; c++) tick(1'b0, 1'b0, 32'd0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: out_valid got %b want 0 at cycle 4", out_valid); end
    tick(1'b0, 1'b0, 32'd0);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1 at cycle 5", out_valid); end
    n_cmp++; if (out_data !== 32'd6) begin n_fail++; $display("FAIL single_data: got %0d want 6", out_data); end
    n_cmp++; if (out_count !== 8'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", out_count); end
    out_ready = 1'b1;
    tick(1'b0, 1'b0, 32'd0);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_three_term();
    tick(1'b1, 1'b0, 32'd100);
    tick(1'b1, 1'b0, 32'd200);
    tick(1'b1, 1'b1, 32'd300);
    wait_valid(10);
    n_cmp++; if (out_data !== 32'd600) begin n_fail++; $display("FAIL three_data: got %0d want 600", out_data); end
    n_cmp++; if (out_count !== 8'd3) begin n_fail++; $display("FAIL three_count: got %0d want 3", out_count); end
    out_ready = 1'b1;
    tick(1'b0, 1'b0, 32'd0);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL three_pop: out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL three_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_d [2];
    logic [7:0]  got_c [2];
    int n = 0;
    out_ready = 1'b1;
    tick(1'b1, 1'b0, 32'd5);
    tick(1'b1, 1'b1, 32'd7);
    tick(1'b1, 1'b1, 32'd11);
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, 1'b0, 32'd0);
      if (out_valid && n < 2) begin
        got_d[n] = out_data;
        got_c[n] = out_count;
        n++;
      end
    end
    out_ready = 1'b0;
    n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL b2b_num: got %0d results want 2", n); end
    if (n == 2) begin
      n_cmp++; if (got_d[0] !== 32'd12 || got_c[0] !== 8'd2) begin n_fail++; $display("FAIL b2b_first: got (%0d,%0d) want (12,2)", got_d[0], got_c[0]); end
      n_cmp++; if (got_d[1] !== 32'd11 || got_c[1] !== 8'd1) begin n_fail++; $display("FAIL b2b_second: got (%0d,%0d) want (11,1)", got_d[1], got_c[1]); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    tick(1'b1, 1'b1, 32'd1);
    tick(1'b1, 1'b1, 32'd2);
    tick(1'b1, 1'b1, 32'd3);
    for (int c = 0; c < 6; c++) tick(1'b0, 1'b0, 32'd0);
    n_cmp++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b want 1", overflow_err); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin n_fail++; $display("FAIL bp_head1: got v=%b d=%0d want v=1 d=1", out_valid, out_data); end
    out_ready = 1'b1;
    tick(1'b0, 1'b0, 32'd0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd2) begin n_fail++; $display("FAIL bp_head2: got v=%b d=%0d want v=1 d=2", out_valid, out_data); end
    tick(1'b0, 1'b0, 32'd0);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid got %b want 0", out_valid); end
    n_cmp++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL bp_sticky: got %b want 1", overflow_err); end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    tick(1'b1, 1'b1, 32'd1);
    tick(1'b1, 1'b1, 32'd2);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 32'd4);
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 32'd0);
    n_cmp++; if (out_data !== 32'd1) begin n_fail++; $display("FAIL fpp_head: got %0d want 1", out_data); end
    out_ready = 1'b1;
    tick(1'b0, 1'b0, 32'd0);
    n_cmp++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b want 0", overflow_err); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd2) begin n_fail++; $display("FAIL fpp_second: got v=%b d=%0d want v=1 d=2", out_valid, out_data); end
    tick(1'b0, 1'b0, 32'd0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd4) begin n_fail++; $display("FAIL fpp_third: got v=%b d=%0d want v=1 d=4", out_valid, out_data); end
    tick(1'b0, 1'b0, 32'd0);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_wrap_sat();
    logic [31:0] exp_sum;
`ifdef MAC_ACC_SAT_EN
    exp_sum = 32'hFFFF_FFFF;
`else
    exp_sum = 32'h0000_0001;
`endif
    tick(1'b1, 1'b0, 32'hFFFF_FFFF);
    tick(1'b1, 1'b1, 32'h0000_0002);
    wait_valid(10);
    n_cmp++; if (out_data !== exp_sum) begin n_fail++; $display("FAIL wrap_data: got %08h want %08h", out_data, exp_sum); end
    n_cmp++; if (out_count !== 8'd2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", out_count); end
    out_ready = 1'b1;
    tick(1'b0, 1'b0, 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_group();
    tick(1'b1, 1'b0, 32'd10);
    tick(1'b1, 1'b0, 32'd20);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 32'd0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== 8'd0 || busy !== 1'b0 || overflow_err !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset: got v=%b d=%0d c=%0d busy=%b ovf=%b want all 0", out_valid, out_data, out_count, busy, overflow_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b1, 1'b1, 32'd9);
    wait_valid(10);
    n_cmp++; if (out_data !== 32'd9 || out_count !== 8'd1) begin n_fail++; $display("FAIL mid_new: got (%0d,%0d) want (9,1)", out_data, out_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_term();
    test_back_to_back();
    test_backpressure();
    test_full_pop_push();
    test_wrap_sat();
    test_reset_mid_group();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
